// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-requester SPI bus arbiter: FSM state
// encodings, requester index constants and a one-hot helper.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    localparam int unsigned REQ_EEPROM = 0;
    localparam int unsigned REQ_HC595  = 1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == 1'(REQ_HC595)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arb_lock_timer.sv
// Idle-cycle counter for the burst lock: cleared outside HOLD, counts while
// the owner is silent, expires on the LOCK_TIMEOUT-th idle cycle (0 = never).
module spi_arb_lock_timer #(
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (LOCK_TIMEOUT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI engine between the EEPROM loader (req0) and the HC595 output
// (req1), owning both chip selects and holding the bus across multi-byte bursts.
// Build option: define SPI_ARB_ROUND_ROBIN_EN for round-robin contention.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_din,
    input  logic [1:0]          req_last,
    output logic [1:0]          req_ready,
    output logic [1:0]          req_done,
    output logic [DATA_W-1:0]   req_dout,
    output logic                eng_send_request,
    output logic [DATA_W-1:0]   eng_din,
    input  logic                eng_processing,
    input  logic                eng_data_valid,
    input  logic [DATA_W-1:0]   eng_dout,
    output logic [1:0]          cs_n,
    output logic                owner,
    output logic                lock_timeout
);

    arb_state_t        r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic              w_pick;
    logic [1:0]        r_cs_n;
    logic [1:0]        r_req_done;
    logic [DATA_W-1:0] r_req_dout;
    logic [DATA_W-1:0] r_eng_din;
    logic              r_last;
    logic              r_dv_d;
    logic              r_lock_timeout;
    logic              w_own_valid;
    logic [DATA_W-1:0] w_own_din;
    logic              w_accept;
    logic              w_dv_rise;
    logic              w_expire;

    assign w_own_valid = req_valid[r_owner];
    assign w_own_din   = r_owner ? req_din[2*DATA_W-1:DATA_W] : req_din[DATA_W-1:0];
    assign w_accept    = (r_state == ST_ISSUE) && w_own_valid && !eng_processing;
    assign w_dv_rise   = (r_state == ST_BUSY) && eng_data_valid && !r_dv_d;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last_owner <= 1'b1;
        end else if ((r_state == ST_IDLE) && |req_valid) begin
            r_last_owner <= w_pick;
        end
    end

    always_comb begin
        if (&req_valid) w_pick = ~r_last_owner;
        else            w_pick = req_valid[REQ_HC595];
    end
`else
    always_comb begin
        w_pick = ~req_valid[REQ_EEPROM];
    end
`endif

    spi_arb_lock_timer #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk      (clk),
        .nreset   (nreset),
        .i_clear  (r_state != ST_HOLD),
        .i_enable ((r_state == ST_HOLD) && !w_own_valid),
        .o_expire (w_expire)
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        unique case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = ST_ISSUE;
                end
            end
            // An abandoned request parks in HOLD; the lock timer frees the bus.
            ST_ISSUE: begin
                if (!w_own_valid)         w_state_nxt = ST_HOLD;
                else if (!eng_processing) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_dv_rise) w_state_nxt = r_last ? ST_RELEASE : ST_HOLD;
            end
            ST_HOLD: begin
                if (w_own_valid)   w_state_nxt = ST_ISSUE;
                else if (w_expire) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state        <= ST_IDLE;
            r_owner        <= 1'b0;
            r_cs_n         <= 2'b11;
            r_req_done     <= 2'b00;
            r_req_dout     <= '0;
            r_eng_din      <= '0;
            r_last         <= 1'b0;
            r_dv_d         <= 1'b0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_owner        <= w_owner_nxt;
            r_dv_d         <= eng_data_valid;
            r_lock_timeout <= w_expire;
            r_req_done     <= w_dv_rise ? req_onehot(r_owner) : 2'b00;
            // Chip select follows the next state so it is glitch-free and the
            // RELEASE cycle always leaves both lines high between owners.
            if ((w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_BUSY) ||
                (w_state_nxt == ST_HOLD)) begin
                r_cs_n <= ~req_onehot(w_owner_nxt);
            end else begin
                r_cs_n <= 2'b11;
            end
            if (w_dv_rise) r_req_dout <= eng_dout;
            if (w_accept) begin
                r_eng_din <= w_own_din;
                r_last    <= req_last[r_owner];
            end
        end
    end

    // The byte is forwarded straight through in the accept cycle so the engine
    // sees it alongside the start strobe; the register holds it afterwards.
    assign eng_din          = w_accept ? w_own_din : r_eng_din;
    assign eng_send_request = w_accept;
    assign req_ready        = w_accept ? req_onehot(r_owner) : 2'b00;
    assign req_done         = r_req_done;
    assign req_dout         = r_req_dout;
    assign cs_n             = r_cs_n;
    assign owner            = r_owner;
    assign lock_timeout     = r_lock_timeout;

endmodule
